// File: rtl/stepper_phase_decoder.sv
// -----------------------------------------------------------------------------
// stepper_phase_decoder
//
// Receive side of the 4-phase one-hot stepper drive (pins a..d = phase 0..3).
// The pins pass through a 2-flop synchroniser and a DEB-sample stability
// filter. Accepted patterns drive a two-state tracker (UNSYNC / TRACK) that
// decodes forward/reverse steps into a signed wrapping position count and
// flags illegal patterns, skipped phases and stalls.
//
// Pipeline: a pattern first sampled at edge k is accepted by the filter at
// edge k+DEB+1 and its decoded results are registered at edge k+DEB+2.
//
// DEB must stay in 1..3 so that a pattern is always accepted well inside
// one drive step period (5 clocks).
//
// Optional feature (compile-time macro STEPPER_ERR_COUNT_EN): adds an 8-bit
// saturating err_count output counting skipped-phase and illegal-pattern
// events. With the macro undefined the port and its logic are absent.
// -----------------------------------------------------------------------------
module stepper_phase_decoder #(
    parameter int POS_W       = 16,
    parameter int DEB         = 2,
    parameter int STALL_LIMIT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             clr,
    output logic [POS_W-1:0] position,
    output logic             step_pulse,
    output logic             dir,
    output logic             locked,
    output logic             phase_err,
    output logic             stalled
`ifdef STEPPER_ERR_COUNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } state_t;

    localparam logic [1:0]       DEB_N     = 2'(DEB);
    localparam int               STALL_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

    // Input synchroniser and filter state
    logic [3:0]         sync_meta;
    logic [3:0]         sync_q;
    logic [3:0]         last_q;
    logic [1:0]         run_q;
    logic [1:0]         run_d;
    logic [3:0]         filt_q;
    logic               acc_vld_q;
    logic               accept;

    // Tracker state
    state_t             state_q;
    state_t             state_d;
    logic [1:0]         phase_q;
    logic [1:0]         phase_d;

    // Decode of the accepted pattern
    logic               is_idle;
    logic               is_onehot;
    logic [1:0]         pat_idx;
    logic [1:0]         delta;
    logic               step_fwd;
    logic               step_rev;
    logic               err_ev;
    logic               enter_track;

    // Stall timer
    logic [STALL_W-1:0] stall_q;
    logic [STALL_W-1:0] stall_d;

    // Map a one-hot phase pattern to its phase index (0..3 for a..d).
    function automatic logic [1:0] onehot_idx(input logic [3:0] pat);
        case (pat)
            4'b0010: onehot_idx = 2'd1;
            4'b0100: onehot_idx = 2'd2;
            4'b1000: onehot_idx = 2'd3;
            default: onehot_idx = 2'd0;
        endcase
    endfunction

    // Two-flop synchroniser on the asynchronous phase pins.
    // NOTE: every clocked register uses <= so all flops sample pre-edge values;
    // a blocking = here would collapse the two synchroniser stages into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 4'b0000;
            sync_q    <= 4'b0000;
        end else begin
            sync_meta <= {d, c, b, a};
            sync_q    <= sync_meta;
        end
    end

    // Run length of identical synchronised samples; accept on reaching DEB.
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        run_d = 2'd1;
        if (sync_q == last_q) begin
            run_d = (run_q >= DEB_N) ? DEB_N : run_q + 2'd1;
        end
        accept = (run_d == DEB_N) && (sync_q != filt_q);
    end

    // Filter registers: last sample, run length and the accepted pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q    <= 4'b0000;
            run_q     <= 2'd0;
            filt_q    <= 4'b0000;
            acc_vld_q <= 1'b0;
        end else begin
            last_q    <= sync_q;
            run_q     <= run_d;
            acc_vld_q <= accept;
            if (accept) begin
                filt_q <= sync_q;
            end
        end
    end

    assign is_idle   = (filt_q == 4'b0000);
    assign is_onehot = $onehot(filt_q);
    assign pat_idx   = onehot_idx(filt_q);
    assign delta     = pat_idx - phase_q;

    // Tracker state register: FSM state and the last tracked phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= UNSYNC;
            phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic and step/error classification of a newly accepted pattern.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_fwd    = 1'b0;
        step_rev    = 1'b0;
        err_ev      = 1'b0;
        enter_track = 1'b0;
        if (acc_vld_q && !is_idle) begin
            case (state_q)
                UNSYNC: begin
                    if (is_onehot) begin
                        state_d     = TRACK;
                        phase_d     = pat_idx;
                        enter_track = 1'b1;
                    end else begin
                        err_ev = 1'b1;
                    end
                end
                TRACK: begin
                    if (!is_onehot) begin
                        err_ev  = 1'b1;
                        state_d = UNSYNC;
                    end else begin
                        case (delta)
                            2'd1: begin
                                step_fwd = 1'b1;
                                phase_d  = pat_idx;
                            end
                            2'd3: begin
                                step_rev = 1'b1;
                                phase_d  = pat_idx;
                            end
                            2'd2: begin
                                // Skipped phase: resync to the new phase, no step.
                                err_ev  = 1'b1;
                                phase_d = pat_idx;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = UNSYNC;
            endcase
        end
    end

    // Stall timer: counts clocks in TRACK since entry or the last step, saturating.
    always_comb begin
        stall_d = stall_q;
        if (state_d != TRACK || step_fwd || step_rev || enter_track || clr) begin
            stall_d = '0;
        end else if (stall_q != STALL_MAX) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    assign locked = (state_q == TRACK);

    // Decoded outputs: step pulse, direction, wrapping position, sticky error, stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            position   <= '0;
            step_pulse <= 1'b0;
            dir        <= 1'b0;
            phase_err  <= 1'b0;
            stall_q    <= '0;
            stalled    <= 1'b0;
        end else begin
            step_pulse <= step_fwd | step_rev;
            if (step_fwd | step_rev) begin
                dir <= step_fwd;
            end
            // clr wins over a coincident step for the count.
            if (clr) begin
                position <= '0;
            end else if (step_fwd) begin
                position <= position + POS_ONE;
            end else if (step_rev) begin
                position <= position - POS_ONE;
            end
            // A coincident error wins over clr so the flag is never lost.
            if (err_ev) begin
                phase_err <= 1'b1;
            end else if (clr) begin
                phase_err <= 1'b0;
            end
            stall_q <= stall_d;
            stalled <= (stall_d == STALL_MAX);
        end
    end

`ifdef STEPPER_ERR_COUNT_EN
    // Saturating count of skipped-phase and illegal-pattern events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= 8'd0;
        end else if (clr) begin
            err_count <= err_ev ? 8'd1 : 8'd0;
        end else if (err_ev && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// -----------------------------------------------------------------------------
// tb_stepper_phase_decoder
//
// Directed stimulus against a behavioural model of the decoder. The model
// keeps a short history of raw pin samples and applies the decoder rules
// with plain phase-index arithmetic; a negedge process compares every
// output against it on every cycle. A second instance with an 8-bit counter
// shares the stimulus to exercise the signed wrap at 7F -> 80. Directed
// literal checks pin latency, wrap, glitch, error, stall and reset cases.
// Build with +define+STEPPER_ERR_COUNT_EN to also check err_count.
// -----------------------------------------------------------------------------
module tb_stepper_phase_decoder;

    localparam int DEB   = 2;
    localparam int LIMIT = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  pins = 4'b0000;

    logic [15:0] position;
    logic        step_pulse, dir, locked, phase_err, stalled;
    logic [7:0]  position8;
    logic        step_pulse8, dir8, locked8, phase_err8, stalled8;
`ifdef STEPPER_ERR_COUNT_EN
    logic [7:0]  err_count, err_count8;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stepper_phase_decoder #(.POS_W(16), .DEB(DEB), .STALL_LIMIT(LIMIT)) dut (
`ifdef STEPPER_ERR_COUNT_EN
        .err_count(err_count),
`endif
        .clk(clk), .rst(rst), .a(pins[0]), .b(pins[1]), .c(pins[2]), .d(pins[3]),
        .clr(clr), .position(position), .step_pulse(step_pulse), .dir(dir),
        .locked(locked), .phase_err(phase_err), .stalled(stalled)
    );

    stepper_phase_decoder #(.POS_W(8), .DEB(DEB), .STALL_LIMIT(LIMIT)) dut8 (
`ifdef STEPPER_ERR_COUNT_EN
        .err_count(err_count8),
`endif
        .clk(clk), .rst(rst), .a(pins[0]), .b(pins[1]), .c(pins[2]), .d(pins[3]),
        .clr(clr), .position(position8), .step_pulse(step_pulse8), .dir(dir8),
        .locked(locked8), .phase_err(phase_err8), .stalled(stalled8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  smp_pins = 4'b0000;
    logic        smp_clr  = 1'b0;
    logic        smp_rst  = 1'b0;
    logic [3:0]  hist [0:DEB+2];
    logic [3:0]  m_filt;
    int          m_locked, m_cur, m_since, m_errcnt;
    logic [31:0] m_pos;
    logic        m_dir, m_step, m_err, m_stalled;

    // Capture what the DUT saw at each rising edge.
    always @(posedge clk) begin
        smp_pins <= pins;
        smp_clr  <= clr;
        smp_rst  <= rst;
    end

    task automatic model_reset();
        for (int i = 0; i <= DEB + 2; i++) hist[i] = 4'b0000;
        m_filt = 4'b0000; m_locked = 0; m_cur = 0; m_since = 0; m_errcnt = 0;
        m_pos = 0; m_dir = 0; m_step = 0; m_err = 0; m_stalled = 0;
    endtask

    task automatic model_edge();
        logic [3:0] p;
        bit stable, fwd, rev, errev, entered;
        int idx, dlt;
        for (int i = DEB + 2; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = smp_pins;
        // Results at this edge come from the pattern seen DEB samples in a row,
        // ending three edges ago (two sync stages plus the filter register).
        p = hist[3];
        stable = 1;
        for (int i = 3; i <= DEB + 2; i++) if (hist[i] != p) stable = 0;
        fwd = 0; rev = 0; errev = 0; entered = 0;
        if (stable && p != m_filt) begin
            m_filt = p;
            if (p != 4'b0000) begin
                if ($countones(p) == 1) begin
                    idx = 0;
                    for (int i = 0; i < 4; i++) if (p == (4'b0001 << i)) idx = i;
                    if (m_locked == 0) begin
                        m_locked = 1; m_cur = idx; entered = 1;
                    end else begin
                        dlt = (idx - m_cur + 4) % 4;
                        if (dlt == 1) fwd = 1;
                        if (dlt == 3) rev = 1;
                        if (dlt == 2) errev = 1;
                        m_cur = idx;
                    end
                end else begin
                    errev = 1; m_locked = 0;
                end
            end
        end
        if (smp_clr) m_pos = 0;
        else if (fwd) m_pos = m_pos + 1;
        else if (rev) m_pos = m_pos - 1;
        m_step = fwd | rev;
        if (m_step) m_dir = fwd;
        if (errev) m_err = 1; else if (smp_clr) m_err = 0;
        if (smp_clr) m_errcnt = errev ? 1 : 0;
        else if (errev && m_errcnt < 255) m_errcnt++;
        if (m_locked == 0 || m_step || entered || smp_clr) m_since = 0;
        else if (m_since < LIMIT) m_since++;
        m_stalled = (m_since == LIMIT);
    endtask

    // Single compare process: advance the model, then check every output.
    always @(negedge clk) begin
        if (!rst || !smp_rst) model_reset();
        else model_edge();
        check("m_position", position, {16'h0, m_pos[15:0]});
        check("m_position8", position8, {24'h0, m_pos[7:0]});
        check("m_step_pulse", step_pulse, m_step);
        check("m_dir", dir, m_dir);
        check("m_locked", locked, m_locked[0]);
        check("m_phase_err", phase_err, m_err);
        check("m_stalled", stalled, m_stalled);
`ifdef STEPPER_ERR_COUNT_EN
        check("m_err_count", err_count, m_errcnt);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] p, input int n);
        pins = p;
        tick(n);
    endtask

    function automatic logic [3:0] ph(input int i);
        int k;
        k = ((i % 4) + 4) % 4;
        return 4'b0001 << k;
    endfunction

    int cur;
    logic seen;

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_position", position, 0);
        check("rst_locked", locked, 0);
        check("rst_phase_err", phase_err, 0);
        check("rst_stalled", stalled, 0);
        rst = 1'b1;

        // Lock on a, then forward a->b->c->d->a.
        cur = 0;
        apply(ph(0), 5);
        check("lock_a", locked, 1);
        check("lock_no_count", position, 0);
        pins = ph(1);
        tick(4);
        check("latency_early", step_pulse, 0);
        tick(1);
        check("latency_k4", step_pulse, 1);
        check("first_step_pos", position, 16'h0001);
        for (int i = 2; i <= 4; i++) apply(ph(i), 5);
        check("fwd_pos", position, 16'h0004);
        check("fwd_dir", dir, 1);
        check("fwd_err", phase_err, 0);

        // Sixteen reverse steps: 4 - 16 = -12.
        for (int i = 0; i < 16; i++) begin
            cur = cur - 1;
            apply(ph(cur), 5);
        end
        check("rev_pos", position, 16'hFFF4);
        check("rev_dir", dir, 0);

        // Forward up to 127, then across the 8-bit signed boundary.
        for (int i = 0; i < 139; i++) begin
            cur = cur + 1;
            apply(ph(cur), 5);
        end
        check("pos_7f", position, 16'h007F);
        check("pos8_7f", position8, 8'h7F);
        cur = cur + 1;
        apply(ph(cur), 5);
        check("pos_80", position, 16'h0080);
        check("pos8_80", position8, 8'h80);

        // clr on the same edge as a step result.
        cur = cur + 1;
        pins = ph(cur);
        tick(4);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_step_pulse", step_pulse, 1);
        check("clr_step_pos", position, 0);
        check("clr_step_dir", dir, 1);

        // One-clock glitch to the next phase is discarded.
        pins = ph(cur + 1);
        tick(1);
        pins = ph(cur);
        seen = 1'b0;
        repeat (10) begin
            tick(1);
            seen = seen | step_pulse;
        end
        check("glitch_no_step", seen, 0);
        check("glitch_pos", position, 0);

        // Skipped phase: error, still locked, no count.
        cur = cur + 2;
        apply(ph(cur), 5);
        check("skip_err", phase_err, 1);
        check("skip_locked", locked, 1);
        check("skip_pos", position, 0);

        clr = 1'b1; tick(1); clr = 1'b0;
        check("clr_err", phase_err, 0);

        // Illegal pattern coincident with clr: error survives, lock lost.
        pins = 4'b0011;
        tick(4);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("illegal_clr_err", phase_err, 1);
        check("illegal_unlock", locked, 0);
        clr = 1'b1; tick(1); clr = 1'b0;

        // Stall: lock on b and hold for LIMIT clocks.
        cur = 1;
        pins = ph(cur);
        tick(4);
        check("stall_prelock", locked, 0);
        tick(1);
        check("stall_lock", locked, 1);
        tick(LIMIT - 1);
        check("stall_before", stalled, 0);
        tick(1);
        check("stall_at_limit", stalled, 1);
        cur = 2;
        pins = ph(cur);
        tick(4);
        check("stall_held", stalled, 1);
        tick(1);
        check("stall_step", step_pulse, 1);
        check("stall_drop", stalled, 0);
        check("stall_pos", position, 16'h0001);

        // 300 illegal patterns.
        for (int i = 0; i < 300; i++) apply((i % 2 == 1) ? 4'b0110 : 4'b0011, 3);
        tick(3);
        check("ill_err", phase_err, 1);
        check("ill_locked", locked, 0);
`ifdef STEPPER_ERR_COUNT_EN
        check("errcnt_sat", err_count, 8'd255);
`endif
        clr = 1'b1; tick(1); clr = 1'b0;
        check("ill_clr_err", phase_err, 0);
`ifdef STEPPER_ERR_COUNT_EN
        check("errcnt_clr", err_count, 8'd0);
`endif
        pins = 4'b0101;
        tick(4);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("err_with_clr", phase_err, 1);
`ifdef STEPPER_ERR_COUNT_EN
        check("errcnt_clr_err", err_count, 8'd1);
`endif
        clr = 1'b1; tick(1); clr = 1'b0;

        // Reset in the middle of a step.
        apply(ph(0), 6);
        apply(ph(1), 5);
        check("pre_rst_pos", position, 16'h0001);
        pins = ph(2);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("mid_rst_pos", position, 0);
        check("mid_rst_dir", dir, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_step", step_pulse, 0);
        tick(1);
        rst = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick(1);
            seen = seen | step_pulse;
        end
        check("resync_no_step", seen, 0);
        check("resync_locked", locked, 1);
        check("resync_pos", position, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Receive side of the 4-phase one-hot stepper drive (phase pins a, b, c, d), as driven by the team's motor phase generator.
- Synchronises and glitch-filters the phase pins, decodes step events and direction, and keeps a signed position count.
- Flags illegal patterns, skipped phases and stalls.
- Used as a loopback monitor on the motor pins and as the position source for game logic.

Parameters:
- POS_W, 16: width of the position counter, two's complement.
- DEB, 2: consecutive identical synchronised samples needed to accept a pattern. Legal range is 1..3, which must stay below the drive step period of 5 clocks.
- STALL_LIMIT, 1000: clocks without a step, while in TRACK, before stalled asserts.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- a, input, 1: phase 0 pin, asynchronous.
- b, input, 1: phase 1 pin, asynchronous.
- c, input, 1: phase 2 pin, asynchronous.
- d, input, 1: phase 3 pin, asynchronous.
- clr, input, 1: synchronous clear of position, phase_err and the stall counter.
- position, output, POS_W: signed step count, +1 per forward step.
- step_pulse, output, 1: one-clock pulse per decoded step.
- dir, output, 1: direction of the last step; 1 = forward (a→b→c→d→a), 0 = reverse.
- locked, output, 1: FSM is in TRACK.
- phase_err, output, 1: sticky error flag.
- stalled, output, 1: no step for STALL_LIMIT clocks while locked.

Behaviour:
- Reset (rst=0, async): synchronisers and filter registers clear to 4'b0000, FSM goes to UNSYNC, and all outputs go to 0.
- Input path: {d,c,b,a} passes through a 2-flop synchroniser, then the filter.
  - The filter accepts a pattern once the synchronised value has been identical for DEB consecutive clocks.
  - A pattern shorter than DEB clocks is discarded and never reaches the decoder.
- Latency: a new stable pattern first sampled at edge k gives decoded results (step_pulse, position, dir, phase_err) registered at edge k+DEB+2.
- Pattern classes:
  - One-hot: valid phase, index 0..3 for a..d.
  - 4'b0000: idle. State and position hold; no error.
  - Any other pattern: illegal.
- FSM state UNSYNC:
  - Accepted one-hot loads cur_phase and moves to TRACK. No step is counted.
  - Illegal pattern sets phase_err and stays in UNSYNC.
- FSM state TRACK (locked=1). With accepted one-hot p:
  - p == cur_phase: no action.
  - p == cur_phase+1 mod 4: position+1, dir=1, step_pulse=1.
  - p == cur_phase-1 mod 4: position-1, dir=0, step_pulse=1.
  - p == cur_phase+2 mod 4 (skipped phase): phase_err=1. position and dir unchanged, cur_phase=p, stays in TRACK.
  - Illegal pattern: phase_err=1, move to UNSYNC, position held.
- position wraps modulo 2^POS_W in both directions, with no saturation.
- phase_err is sticky and clears only on clr or reset.
- Stall counter:
  - Counts clocks in TRACK since the last step or since entry into TRACK.
  - At STALL_LIMIT it saturates and stalled=1.
  - Cleared by a step, clr, or leaving TRACK; stalled drops on the same edge.
  - stalled is always 0 in UNSYNC.
- clr:
  - On the edge it is sampled: position=0, phase_err=0, stall counter=0, stalled=0.
  - FSM state and cur_phase are unaffected.
- clr coincident with a step:
  - clr wins for position, which becomes 0.
  - step_pulse and dir still reflect the step.
- Illegal pattern coincident with clr: phase_err ends at 1, because the error sets after the clear.
- Reset mid-step: the in-flight pattern is discarded. After release, the first accepted one-hot only resynchronises and counts no step.

Optional Feature:
- Macro: STEPPER_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [7:0]. Increments on each skipped-phase or illegal-pattern event and saturates at 255.
  - Cleared by clr and reset; clr coincident with an error gives 1.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Drive a→b→c→d→a, 5 clocks each, from reset (DEB=2) → locked after the first a. 4 step_pulses, each at edge k+4; position=4, dir=1, phase_err=0.
- Drive d→c→b→a repeatedly, 12 steps after lock → position=-12 (16'hFFF4), dir=0.
- With position=16'h7FFF, apply one forward step → position=16'h8000. With position=0 and clr asserted on the same edge as a step result → position=0, step_pulse=1.
- Apply a 1-clock glitch a→b→a (b held 1 clock) → no step_pulse, position unchanged. Apply a→c → phase_err=1, position unchanged, locked=1. Apply 4'b0011 → phase_err=1, locked=0.
- Hold phase b for 1000 clocks after lock → stalled=1 at clock 1000. A subsequent c step → stalled=0 on the same edge as step_pulse.
- With STEPPER_ERR_COUNT_EN, inject 300 illegal patterns → err_count=255. Assert clr → err_count=0, phase_err=0. Pulse rst low mid-pattern → all outputs 0 and locked=0.
